// File: rtl/cmos_cap_pkg.sv
// Shared types and default widths for the DVP capture path.
package cmos_cap_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SKIP   = 2'd1,
      ARMED  = 2'd2,
      ACTIVE = 2'd3
   } cap_state_e;

   localparam int DEF_IN_W     = 8;
   localparam int DEF_BPP      = 2;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_SKIP     = 10;
   localparam int DEF_CNT_W    = 12;
   localparam int FCNT_W       = 8;
   localparam int SKIP_W       = 16;

endpackage

// File: rtl/cmos_byte_packer.sv
// Packs sensor bytes into pixels, MSB-first; flags line ends and
// whether the line ended mid-pixel.
module cmos_byte_packer
   import cmos_cap_pkg::*;
#(
   parameter int IN_W = DEF_IN_W,
   parameter int BPP  = DEF_BPP
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 href_i,
   input  logic [IN_W-1:0]      data_i,
   output logic                 pix_done_o,
   output logic [IN_W*BPP-1:0]  pix_data_o,
   output logic                 line_end_o,
   output logic                 partial_o
);

   localparam int PIX_W = IN_W * BPP;
   localparam int IDX_W = (BPP > 1) ? $clog2(BPP) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(BPP - 1);

   logic [IDX_W-1:0] idx_q;
   logic [PIX_W-1:0] sh_q;
   logic [PIX_W-1:0] sh_d;
   logic [PIX_W-1:0] pix_q;
   logic             done_q;
   logic             href_q;
   logic             end_q;
   logic             part_q;

   // Shifting BPP bytes fully replaces stale content, so no clear needed.
   assign sh_d = (sh_q << IN_W) | PIX_W'(data_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         sh_q   <= '0;
         pix_q  <= '0;
         done_q <= 1'b0;
         href_q <= 1'b0;
         end_q  <= 1'b0;
         part_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         end_q  <= 1'b0;
         href_q <= href_i;
         if (href_i) begin
            sh_q <= sh_d;
            if (idx_q == LAST) begin
               idx_q  <= '0;
               done_q <= 1'b1;
               pix_q  <= sh_d;
            end else begin
               idx_q <= idx_q + IDX_W'(1);
            end
         end else begin
            idx_q <= '0;
            if (href_q) begin
               end_q  <= 1'b1;
               part_q <= (idx_q != '0);
            end
         end
      end
   end

   assign pix_done_o = done_q;
   assign pix_data_o = pix_q;
   assign line_end_o = end_q;
   assign partial_o  = part_q;

endmodule

// File: rtl/cmos_capture_win.sv
// DVP capture: frame skip, run-time crop window, pixel strobes.
// Optional line-format check enabled by `CAPTURE_LINE_CHECK_EN.
module cmos_capture_win
   import cmos_cap_pkg::*;
#(
   parameter int IN_W          = DEF_IN_W,
   parameter int BYTES_PER_PIX = DEF_BPP,
   parameter int H_ACTIVE      = DEF_H_ACTIVE,
   parameter int SKIP_FRAMES   = DEF_SKIP,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          init_done,
   input  logic                          cmos_vsync,
   input  logic                          cmos_href,
   input  logic [IN_W-1:0]               cmos_data,
   input  logic [CNT_W-1:0]              win_x0,
   input  logic [CNT_W-1:0]              win_y0,
   input  logic [CNT_W-1:0]              win_w,
   input  logic [CNT_W-1:0]              win_h,
   output logic                          pix_valid,
   output logic [IN_W*BYTES_PER_PIX-1:0] pix_data,
   output logic                          frame_valid,
   output logic                          frame_start,
   output logic [FCNT_W-1:0]             frame_cnt,
   output logic                          line_err
);

   localparam int PIX_W = IN_W * BYTES_PER_PIX;
   localparam logic [CNT_W-1:0]  CMAX   = '1;
   localparam logic [SKIP_W-1:0] SKIP_N = SKIP_W'(SKIP_FRAMES);

   if (H_ACTIVE < 1 || H_ACTIVE > (1 << CNT_W) - 1) begin : g_cfg_chk
      $error("H_ACTIVE does not fit in CNT_W");
   end

   logic             vs_q;
   logic             vs_d1_q;
   logic             href_q;
   logic [IN_W-1:0]  data_q;
   logic             vs_fall;
   logic             vs_rise;
   logic             href_eff;

   logic             pk_done;
   logic [PIX_W-1:0] pk_pix;
   logic             pk_end;
   logic             pk_part;

   logic [CNT_W-1:0] x_q;
   logic [CNT_W-1:0] y_q;
   logic [CNT_W-1:0] x0_q;
   logic [CNT_W-1:0] y0_q;
   logic [CNT_W-1:0] w_q;
   logic [CNT_W-1:0] h_q;
   logic [CNT_W:0]   x_end;
   logic [CNT_W:0]   y_end;
   logic             in_win;

   cap_state_e        state_q;
   logic [SKIP_W-1:0] skip_q;
   logic [FCNT_W-1:0] fcnt_q;
   logic              pv_q;
   logic [PIX_W-1:0]  pd_q;
   logic              fv_q;
   logic              fs_q;
   logic              started_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q    <= 1'b0;
         vs_d1_q <= 1'b0;
         href_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         vs_q    <= cmos_vsync;
         vs_d1_q <= vs_q;
         href_q  <= cmos_href;
         data_q  <= cmos_data;
      end
   end

   assign vs_fall  = vs_d1_q & ~vs_q;
   assign vs_rise  = ~vs_d1_q & vs_q;
   // Bytes during vertical blanking are never pixels.
   assign href_eff = href_q & ~vs_q;

   cmos_byte_packer #(
      .IN_W (IN_W),
      .BPP  (BYTES_PER_PIX)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .href_i     (href_eff),
      .data_i     (data_q),
      .pix_done_o (pk_done),
      .pix_data_o (pk_pix),
      .line_end_o (pk_end),
      .partial_o  (pk_part)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q  <= '0;
         y_q  <= '0;
         x0_q <= '0;
         y0_q <= '0;
         w_q  <= '0;
         h_q  <= '0;
      end else begin
         if (pk_end) begin
            x_q <= '0;
         end else if (pk_done && x_q != CMAX) begin
            x_q <= x_q + CNT_W'(1);
         end
         if (vs_fall) begin
            y_q  <= '0;
            x0_q <= win_x0;
            y0_q <= win_y0;
            w_q  <= win_w;
            h_q  <= win_h;
         end else if (pk_end && x_q != '0 && y_q != CMAX) begin
            y_q <= y_q + CNT_W'(1);
         end
      end
   end

   // One extra bit keeps origin+size from wrapping past the counter range.
   assign x_end  = {1'b0, x0_q} + {1'b0, w_q};
   assign y_end  = {1'b0, y0_q} + {1'b0, h_q};
   assign in_win = (x_q >= x0_q) && ({1'b0, x_q} < x_end) &&
                   (y_q >= y0_q) && ({1'b0, y_q} < y_end);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         skip_q    <= '0;
         fcnt_q    <= '0;
         pv_q      <= 1'b0;
         pd_q      <= '0;
         fv_q      <= 1'b0;
         fs_q      <= 1'b0;
         started_q <= 1'b0;
      end else begin
         pv_q <= 1'b0;
         fs_q <= 1'b0;
         if (pk_done) begin
            pd_q <= pk_pix;
         end
         if (!init_done) begin
            state_q <= IDLE;
            fv_q    <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  skip_q  <= '0;
                  state_q <= SKIP;
               end
               SKIP: begin
                  if (skip_q == SKIP_N) begin
                     state_q <= ARMED;
                  end else if (vs_fall) begin
                     skip_q <= skip_q + SKIP_W'(1);
                  end
               end
               ARMED: begin
                  if (vs_fall) begin
                     state_q   <= ACTIVE;
                     fv_q      <= 1'b1;
                     started_q <= 1'b0;
                  end
               end
               ACTIVE: begin
                  if (vs_rise) begin
                     state_q <= ARMED;
                     fv_q    <= 1'b0;
                     fcnt_q  <= fcnt_q + FCNT_W'(1);
                  end else if (pk_done && in_win) begin
                     pv_q      <= 1'b1;
                     fs_q      <= ~started_q;
                     started_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef CAPTURE_LINE_CHECK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state_q == ACTIVE && pk_end &&
                   (pk_part || x_q != CNT_W'(H_ACTIVE))) begin
         err_q <= 1'b1;
      end
   end

   assign line_err = err_q;
`else
   logic part_unused;
   assign part_unused = pk_part;
   assign line_err    = 1'b0;
`endif

   assign pix_valid   = pv_q;
   assign pix_data    = pd_q;
   assign frame_valid = fv_q;
   assign frame_start = fs_q;
   assign frame_cnt   = fcnt_q;

endmodule
